// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared constants and types for the SD bus arbiter
//
// Holds the arbiter state encoding, the client-id constants and the sector
// width. The arbiter top and the round-robin picker import it.
package sd_pkg;

  localparam int SEC_W = 32;

  // Client identifiers; the round-robin "last" register holds one of these.
  localparam logic CLIENT_A = 1'b0;
  localparam logic CLIENT_B = 1'b1;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_BUSY     = 3'd3,
    ST_COMPLETE = 3'd4
  } sd_state_t;

endpackage

// File: rtl/sd_rr_arb2.sv
// rtl/sd_rr_arb2.sv - two-input round-robin picker (combinational)
//
// Ports:
//   req_a, req_b : client request levels
//   last         : client granted most recently (CLIENT_A / CLIENT_B)
//   gnt_id       : chosen client, meaningful only when gnt_valid is high
//   gnt_valid    : at least one client is requesting
module sd_rr_arb2
  import sd_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic gnt_id,
  output logic gnt_valid
);

  always_comb begin
    gnt_valid = req_a | req_b;
    gnt_id    = CLIENT_A;
    if (req_a && req_b) begin
      // Contention: the client that did not win last time goes next.
      gnt_id = (last == CLIENT_A) ? CLIENT_B : CLIENT_A;
    end else if (req_b) begin
      gnt_id = CLIENT_B;
    end
  end

endmodule

// File: rtl/sd_bus_arbiter.sv
// rtl/sd_bus_arbiter.sv - SD SPI bus sequencer and two-client round-robin arbiter
//
// Holds the bus for the init engine until init_o, then grants single-block
// write/read transactions from clients A and B to the write/read engines and
// muxes SD_cs/SD_datain from whichever engine owns the bus.
//
// Optional feature macro: SD_ARB_TIMEOUT_EN adds a BUSY watchdog of
// TIMEOUT_CYCLES SD_clk cycles; without it BUSY waits forever, done_err = 0.
//
// Ports:
//   SD_clk, rst_n                 : clock, async active-low reset
//   init_o                        : init engine complete (level)
//   SD_cs_i/_w/_r, SD_datain_i/_w/_r : engine bus drives (init/write/read)
//   write_o, read_o               : engine block-done levels
//   write_req, read_req           : one-cycle engine start pulses
//   write_sec, read_sec           : registered sector for each engine
//   SD_cs, SD_datain              : muxed bus to the card
//   a_req/a_wr/a_sec, b_*         : client request, direction (1 = write), sector
//   a_ack, b_ack                  : one-cycle grant pulses
//   a_done, b_done, done_err      : one-cycle completion pulses, 1 = timed out
//   busy                          : high in every state except IDLE
module sd_bus_arbiter
  import sd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic             SD_clk,
  input  logic             rst_n,
  input  logic             init_o,
  input  logic             SD_cs_i,
  input  logic             SD_datain_i,
  input  logic             SD_cs_w,
  input  logic             SD_datain_w,
  input  logic             SD_cs_r,
  input  logic             SD_datain_r,
  input  logic             write_o,
  input  logic             read_o,
  output logic             write_req,
  output logic             read_req,
  output logic [SEC_W-1:0] write_sec,
  output logic [SEC_W-1:0] read_sec,
  output logic             SD_cs,
  output logic             SD_datain,
  input  logic             a_req,
  input  logic             b_req,
  input  logic             a_wr,
  input  logic             b_wr,
  input  logic [SEC_W-1:0] a_sec,
  input  logic [SEC_W-1:0] b_sec,
  output logic             a_ack,
  output logic             b_ack,
  output logic             a_done,
  output logic             b_done,
  output logic             done_err,
  output logic             busy
);

  sd_state_t state;
  logic      last;       // client granted most recently
  logic      owner;      // client owning the current transaction
  logic      wr;         // current transaction is a write
  logic      done_prev;  // previous value of the selected engine done

  logic             gnt_id;
  logic             gnt_valid;
  logic             gnt_wr;
  logic [SEC_W-1:0] gnt_sec;
  logic             sel_done;
  logic             done_rise;

  sd_rr_arb2 u_rr (
    .req_a     (a_req),
    .req_b     (b_req),
    .last      (last),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  assign gnt_wr    = (gnt_id == CLIENT_A) ? a_wr  : b_wr;
  assign gnt_sec   = (gnt_id == CLIENT_A) ? a_sec : b_sec;
  assign sel_done  = wr ? write_o : read_o;
  assign done_rise = sel_done & ~done_prev;
  assign busy      = (state != ST_IDLE);

`ifdef SD_ARB_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] to_cnt;
  logic        done_err_q;
  assign done_err = done_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign done_err       = 1'b0;
`endif

  always_ff @(posedge SD_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      last      <= CLIENT_B;
      owner     <= CLIENT_A;
      wr        <= 1'b0;
      done_prev <= 1'b0;
      write_sec <= '0;
      read_sec  <= '0;
      write_req <= 1'b0;
      read_req  <= 1'b0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_done    <= 1'b0;
      b_done    <= 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
      to_cnt     <= '0;
      done_err_q <= 1'b0;
`endif
    end else begin
      // All handshake outputs are single-cycle pulses.
      write_req <= 1'b0;
      read_req  <= 1'b0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_done    <= 1'b0;
      b_done    <= 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
      done_err_q <= 1'b0;
`endif
      case (state)
        ST_INIT: begin
          if (init_o) state <= ST_IDLE;
        end

        ST_IDLE: begin
          if (gnt_valid) begin
            owner <= gnt_id;
            wr    <= gnt_wr;
            if (gnt_wr) write_sec <= gnt_sec;
            else        read_sec  <= gnt_sec;
            a_ack     <= (gnt_id == CLIENT_A);
            b_ack     <= (gnt_id == CLIENT_B);
            write_req <= gnt_wr;
            read_req  <= ~gnt_wr;
            // Cleared here and held through ISSUE so a done level that is
            // already high when BUSY starts still counts as an edge.
            done_prev <= 1'b0;
            state     <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          last  <= owner;
`ifdef SD_ARB_TIMEOUT_EN
          to_cnt <= '0;
`endif
          state <= ST_BUSY;
        end

        ST_BUSY: begin
          done_prev <= sel_done;
          if (done_rise) begin
            a_done <= (owner == CLIENT_A);
            b_done <= (owner == CLIENT_B);
            state  <= ST_COMPLETE;
          end
`ifdef SD_ARB_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            a_done     <= (owner == CLIENT_A);
            b_done     <= (owner == CLIENT_B);
            done_err_q <= 1'b1;
            state      <= ST_COMPLETE;
          end else begin
            to_cnt <= to_cnt + 32'd1;
          end
`endif
        end

        ST_COMPLETE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

  // Bus mux: combinational from the registered state, no added latency.
  always_comb begin
    SD_cs     = 1'b1;
    SD_datain = 1'b1;
    case (state)
      ST_INIT: begin
        SD_cs     = SD_cs_i;
        SD_datain = SD_datain_i;
      end
      ST_BUSY: begin
        SD_cs     = wr ? SD_cs_w     : SD_cs_r;
        SD_datain = wr ? SD_datain_w : SD_datain_r;
      end
      default: begin
        SD_cs     = 1'b1;
        SD_datain = 1'b1;
      end
    endcase
  end

endmodule
